// File: rtl/vend_pkg.sv
// Shared definitions for the vending machine coin path: coin values in
// half-coin units, the change dispenser state encoding and default widths.
package vend_pkg;

  localparam int DEF_AMT_W = 4;
  localparam int COIN_HALF = 1;
  localparam int COIN_ONE  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_WAIT_ACK,
    ST_FINISH,
    ST_FAULT
  } vend_state_e;

endpackage

// File: rtl/vend_coin_tube.sv
// Inventory counter for one coin tube: saturates at the top on refill,
// never wraps below zero on dispense, and a simultaneous refill and
// dispense cancel out.
module vend_coin_tube #(
  parameter int TUBE_W    = 6,
  parameter int TUBE_INIT = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [TUBE_W-1:0] cnt,
  output logic              empty
);

  localparam logic [TUBE_W-1:0] CNT_MAX  = '1;
  localparam logic [TUBE_W-1:0] CNT_INIT = TUBE_W'(TUBE_INIT);

  // up/down count with saturation at both ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= CNT_INIT;
    end else if (inc && !dec) begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  assign empty = (cnt == '0);

endmodule

// File: rtl/vend_change_dispenser.sv
// Change payout controller: pays an amount (half-coin units) greedily with
// one-coins then half-coins, drives fixed-width hopper eject pulses, waits
// for the hopper drop confirmation and tracks both tube inventories.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W     = DEF_AMT_W,
  parameter int TUBE_W    = 6,
  parameter int TUBE_INIT = 20,
  parameter int PULSE_CYC = 4,
  parameter int ACK_TO    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [AMT_W-1:0]  amount,
  input  logic              coin_ack,
  input  logic              refill_one,
  input  logic              refill_half,
  input  logic              fault_clr,
  output logic              busy,
  output logic              eject_one,
  output logic              eject_half,
  output logic              done,
  output logic              short,
  output logic              fault,
  output logic [AMT_W-1:0]  remaining,
  output logic [TUBE_W-1:0] cnt_one,
  output logic [TUBE_W-1:0] cnt_half
);

  localparam int               AT_W       = $clog2(ACK_TO + 1);
  localparam logic [3:0]       PULSE_LAST = 4'(PULSE_CYC - 1);
  localparam logic [AT_W-1:0]  ACK_LAST   = AT_W'(ACK_TO - 1);
  localparam logic [AMT_W-1:0] AMT_ONE    = AMT_W'(COIN_ONE);
  localparam logic [AMT_W-1:0] AMT_HALF   = AMT_W'(COIN_HALF);

  vend_state_e      state;
  logic             sel_one;   // coin type of the payout in flight
  logic             ack_seen;  // hopper already confirmed during the pulse
  logic [3:0]       pcnt;
  logic [AT_W-1:0]  acnt;
  logic             empty_one;
  logic             empty_half;
  logic             ack_take;
  logic             dec_one;
  logic             dec_half;

  // a drop confirmation is taken once per coin, during the pulse or after it
  assign ack_take = coin_ack &&
                    (((state == ST_EJECT) && !ack_seen) || (state == ST_WAIT_ACK));
  assign dec_one  = ack_take && sel_one;
  assign dec_half = ack_take && !sel_one;

  vend_coin_tube #(.TUBE_W(TUBE_W), .TUBE_INIT(TUBE_INIT)) u_tube_one (
    .clk   (clk),
    .rst   (rst),
    .inc   (refill_one),
    .dec   (dec_one),
    .cnt   (cnt_one),
    .empty (empty_one)
  );

  vend_coin_tube #(.TUBE_W(TUBE_W), .TUBE_INIT(TUBE_INIT)) u_tube_half (
    .clk   (clk),
    .rst   (rst),
    .inc   (refill_half),
    .dec   (dec_half),
    .cnt   (cnt_half),
    .empty (empty_half)
  );

  // payout FSM with pulse and ack timers; all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      eject_one  <= 1'b0;
      eject_half <= 1'b0;
      done       <= 1'b0;
      short      <= 1'b0;
      fault      <= 1'b0;
      remaining  <= '0;
      sel_one    <= 1'b0;
      ack_seen   <= 1'b0;
      pcnt       <= '0;
      acnt       <= '0;
    end else begin
      done  <= 1'b0;
      short <= 1'b0;
      if (ack_take) remaining <= remaining - (sel_one ? AMT_ONE : AMT_HALF);
      case (state)
        ST_IDLE: begin
          if (req) begin
            remaining <= amount;
            busy      <= 1'b1;
            state     <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          ack_seen <= 1'b0;
          pcnt     <= '0;
          acnt     <= '0;
          if ((remaining >= AMT_ONE) && !empty_one) begin
            sel_one   <= 1'b1;
            eject_one <= 1'b1;
            state     <= ST_EJECT;
          end else if ((remaining >= AMT_HALF) && !empty_half) begin
            sel_one    <= 1'b0;
            eject_half <= 1'b1;
            state      <= ST_EJECT;
          end else begin
            done  <= 1'b1;
            short <= (remaining != '0);
            state <= ST_FINISH;
          end
        end
        ST_EJECT: begin
          if (ack_take) ack_seen <= 1'b1;
          if (pcnt == PULSE_LAST) begin
            eject_one  <= 1'b0;
            eject_half <= 1'b0;
            state      <= (ack_seen || ack_take) ? ST_SELECT : ST_WAIT_ACK;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_take) begin
            state <= ST_SELECT;
          end else if (acnt == ACK_LAST) begin
            fault <= 1'b1;
            state <= ST_FAULT;
          end else begin
            acnt <= acnt + 1'b1;
          end
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_FAULT: begin
          if (fault_clr) begin
            fault <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
